// File: rtl/node_rec_collector.sv
// Registers the 32 per-node CAN receive-request strobes into one vector and
// derives any/multi/lowest-index summary flags from the same sampled word.
module node_rec_collector (
    input  logic        clk,
    input  logic        rst,
    input  logic        can_rec0,
    input  logic        can_rec1,
    input  logic        can_rec2,
    input  logic        can_rec3,
    input  logic        can_rec4,
    input  logic        can_rec5,
    input  logic        can_rec6,
    input  logic        can_rec7,
    input  logic        can_rec8,
    input  logic        can_rec9,
    input  logic        can_rec10,
    input  logic        can_rec11,
    input  logic        can_rec12,
    input  logic        can_rec13,
    input  logic        can_rec14,
    input  logic        can_rec15,
    input  logic        can_rec16,
    input  logic        can_rec17,
    input  logic        can_rec18,
    input  logic        can_rec19,
    input  logic        can_rec20,
    input  logic        can_rec21,
    input  logic        can_rec22,
    input  logic        can_rec23,
    input  logic        can_rec24,
    input  logic        can_rec25,
    input  logic        can_rec26,
    input  logic        can_rec27,
    input  logic        can_rec28,
    input  logic        can_rec29,
    input  logic        can_rec30,
    input  logic        can_rec31,
    output logic [31:0] can_rec,
    output logic        rec_any,
    output logic        rec_multi,
    output logic [4:0]  rec_idx
);

    logic [31:0] word;
    logic        any_d;
    logic        multi_d;
    logic [4:0]  idx_d;

    assign word = {can_rec31, can_rec30, can_rec29, can_rec28,
                   can_rec27, can_rec26, can_rec25, can_rec24,
                   can_rec23, can_rec22, can_rec21, can_rec20,
                   can_rec19, can_rec18, can_rec17, can_rec16,
                   can_rec15, can_rec14, can_rec13, can_rec12,
                   can_rec11, can_rec10, can_rec9,  can_rec8,
                   can_rec7,  can_rec6,  can_rec5,  can_rec4,
                   can_rec3,  can_rec2,  can_rec1,  can_rec0};

    // Clearing the lowest set bit leaves something iff two or more bits were set.
    always_comb begin
        any_d   = |word;
        multi_d = |(word & (word - 32'd1));
        idx_d   = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (word[i]) idx_d = 5'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            can_rec   <= 32'h0;
            rec_any   <= 1'b0;
            rec_multi <= 1'b0;
            rec_idx   <= 5'd0;
        end else begin
            can_rec   <= word;
            rec_any   <= any_d;
            rec_multi <= multi_d;
            rec_idx   <= idx_d;
        end
    end

endmodule

// File: tb/tb_node_rec_collector.sv
// Directed bench for node_rec_collector: reset, single/walking nodes,
// multiple requests, all/none and mid-stream reset.
module tb_node_rec_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [31:0] can_rec;
    logic        rec_any;
    logic        rec_multi;
    logic [4:0]  rec_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    node_rec_collector dut (
        .clk(clk), .rst(rst),
        .can_rec0(din[0]),   .can_rec1(din[1]),   .can_rec2(din[2]),   .can_rec3(din[3]),
        .can_rec4(din[4]),   .can_rec5(din[5]),   .can_rec6(din[6]),   .can_rec7(din[7]),
        .can_rec8(din[8]),   .can_rec9(din[9]),   .can_rec10(din[10]), .can_rec11(din[11]),
        .can_rec12(din[12]), .can_rec13(din[13]), .can_rec14(din[14]), .can_rec15(din[15]),
        .can_rec16(din[16]), .can_rec17(din[17]), .can_rec18(din[18]), .can_rec19(din[19]),
        .can_rec20(din[20]), .can_rec21(din[21]), .can_rec22(din[22]), .can_rec23(din[23]),
        .can_rec24(din[24]), .can_rec25(din[25]), .can_rec26(din[26]), .can_rec27(din[27]),
        .can_rec28(din[28]), .can_rec29(din[29]), .can_rec30(din[30]), .can_rec31(din[31]),
        .can_rec(can_rec), .rec_any(rec_any), .rec_multi(rec_multi), .rec_idx(rec_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] ev, input logic eany,
                       input logic emulti, input logic [4:0] eidx);
        n_cmp++;
        assert (can_rec === ev) else begin
            n_err++;
            $error("FAIL %s can_rec: got %h want %h", tag, can_rec, ev);
        end
        n_cmp++;
        assert (rec_any === eany) else begin
            n_err++;
            $error("FAIL %s rec_any: got %b want %b", tag, rec_any, eany);
        end
        n_cmp++;
        assert (rec_multi === emulti) else begin
            n_err++;
            $error("FAIL %s rec_multi: got %b want %b", tag, rec_multi, emulti);
        end
        n_cmp++;
        assert (rec_idx === eidx) else begin
            n_err++;
            $error("FAIL %s rec_idx: got %0d want %0d", tag, rec_idx, eidx);
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 32'hFFFF_FFFF;
        tick();
        chk("reset", 32'h0, 1'b0, 1'b0, 5'd0);

        rst = 1'b0;
        din = 32'h0;
        tick();
        chk("idle", 32'h0, 1'b0, 1'b0, 5'd0);

        din = 32'h0000_0001; tick(); chk("node0",  32'h0000_0001, 1'b1, 1'b0, 5'd0);
        din = 32'h0000_0002; tick(); chk("node1",  32'h0000_0002, 1'b1, 1'b0, 5'd1);
        din = 32'h4000_0000; tick(); chk("node30", 32'h4000_0000, 1'b1, 1'b0, 5'd30);
        din = 32'h8000_0000; tick(); chk("node31", 32'h8000_0000, 1'b1, 1'b0, 5'd31);

        // One-cycle strobe must not stick.
        din = 32'h0; tick(); chk("strobe_drop", 32'h0, 1'b0, 1'b0, 5'd0);

        for (int n = 0; n < 32; n++) begin
            din = 32'h1 << n;
            tick();
            chk($sformatf("walk%0d", n), 32'h1 << n, 1'b1, 1'b0, 5'(n));
        end

        // Held strobe stays set each cycle.
        din = 32'h0000_0100; tick(); chk("hold_a", 32'h0000_0100, 1'b1, 1'b0, 5'd8);
        tick();                      chk("hold_b", 32'h0000_0100, 1'b1, 1'b0, 5'd8);

        din = 32'h8002_0008; tick(); chk("multi", 32'h8002_0008, 1'b1, 1'b1, 5'd3);
        din = 32'hC000_0000; tick(); chk("top_two", 32'hC000_0000, 1'b1, 1'b1, 5'd30);
        din = 32'hFFFF_FFFF; tick(); chk("all", 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd0);
        din = 32'h0;         tick(); chk("none", 32'h0, 1'b0, 1'b0, 5'd0);

        din = 32'hA5A5_A5A5; tick(); chk("pattern", 32'hA5A5_A5A5, 1'b1, 1'b1, 5'd0);
        rst = 1'b1;          tick(); chk("mid_reset", 32'h0, 1'b0, 1'b0, 5'd0);
        rst = 1'b0;          tick(); chk("post_reset", 32'hA5A5_A5A5, 1'b1, 1'b1, 5'd0);
        din = 32'h5A5A_5A5A; tick(); chk("pattern2", 32'h5A5A_5A5A, 1'b1, 1'b1, 5'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/node_rec_collector.md
Name: node_rec_collector

Overview:
- Collects the 32 per-node CAN receive-request strobes (one per CAN bus node) into one registered 32-bit vector for the MOPS-Hub bus arbitration logic.
- Also provides summary flags:
  - any request pending;
  - more than one request pending;
  - index of the lowest-numbered requesting node.
- Sits between the per-node CAN receiver instances and the hub's receive arbiter/multiplexer.

Parameters:
- None. Node count is fixed at 32; each node has its own scalar input port.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- can_rec0 … can_rec31  input  1 each  receive-request strobe from CAN node n (32 separate scalar ports)
- can_rec  output  32  packed request vector; bit n = registered can_recn
- rec_any  output  1  high when any bit of can_rec is set
- rec_multi  output  1  high when two or more bits of can_rec are set
- rec_idx  output  5  index of the lowest set bit of can_rec; 0 when none set

Behaviour:
- Mapping: can_rec[n] is sampled from input can_recn, n = 0..31; no reordering or inversion.
  - can_rec0 maps to the LSB (bit 0).
  - can_rec31 maps to the MSB (bit 31).
- Timing: all outputs are registered.
  - Input values present at rising edge k appear on can_rec at edge k (visible after k).
  - Latency is one clock cycle.
  - No combinational path from any input to any output.
- Summary flags are computed from the same sampled input word as can_rec, so all outputs are mutually consistent in every cycle.
- rec_any = OR of the sampled word.
- rec_multi = 1 iff the population count of the sampled word is ≥ 2.
- rec_idx = lowest-numbered set bit (priority encoder, bit 0 highest priority); 5'd0 when the word is zero. Use rec_any to tell "node 0" from "none".
- Reset:
  - While rst = 1 at a rising edge: can_rec = 32'h0, rec_any = 0, rec_multi = 0, rec_idx = 0.
  - Reset overrides input sampling.
  - First valid sample is taken at the first edge with rst = 0.
  - Reset asserted mid-operation clears all outputs at the next edge regardless of inputs.
- Level semantics: inputs are treated as levels, not edges.
  - No latching or stickiness: a strobe held for N cycles produces N cycles of the bit set.
  - A 1-cycle strobe produces exactly one cycle of the bit set.
- Simultaneous requests: all set bits are reported in can_rec; rec_idx selects the lowest and rec_multi = 1.
- Inputs are assumed synchronous to clk. No synchronizers inside; the instantiating level handles any CDC.
- X inputs are not specified; the environment must drive all 32 inputs to defined values after reset.

Test Plan:
- Reset check: hold rst = 1 with all inputs = 1 → after the edge, can_rec = 32'h0, rec_any = 0, rec_multi = 0, rec_idx = 0.
- Single-node walk: release reset, all inputs 0, then drive one input high per 10 ns slot in turn → each result appears one cycle after its input is sampled:
  - can_rec0 = 1 → can_rec = 32'h00000001, rec_idx = 0, rec_any = 1, rec_multi = 0.
  - can_rec1 = 1 → can_rec = 32'h00000002, rec_idx = 1.
  - can_rec30 = 1 → can_rec = 32'h40000000, rec_idx = 30.
  - can_rec31 = 1 → can_rec = 32'h80000000, rec_idx = 31.
- Walking-one sweep: can_rec0 … can_rec31 each high for one cycle → can_rec = 1<<n and rec_idx = n one cycle later; rec_multi never asserts.
- Multiple requests: can_rec3 = can_rec17 = can_rec31 = 1 → can_rec = 32'h80020008, rec_idx = 3, rec_multi = 1, rec_any = 1.
- All/none: all 32 inputs = 1 → can_rec = 32'hFFFFFFFF, rec_idx = 0, rec_multi = 1. Then all inputs = 0 → next cycle can_rec = 0, rec_any = 0, rec_multi = 0, rec_idx = 0.
- Reset mid-stream: inputs = 32'hA5A5A5A5 pattern, assert rst for one cycle → outputs clear that edge. Deassert rst → pattern reappears one cycle later with rec_idx = 0 (bit 0 set).
